knight_scanner: RTL and testbench

Parametrised N-lamp scanner, successor to the fixed 8-lamp, 14-step knight flasher. Lamp count is a parameter, and an internal prescaler with a runtime rate input sets the step speed. Four display modes: bounce dot, rotate, fill bar, dot with trail. Drives LED banks directly, and exposes step/cycle strobes for chaining or sync.

---
 rtl/knight_pkg.sv | 27 ++
 rtl/knight_prescaler.sv | 38 +++
 rtl/knight_scanner.sv | 120 ++++++++++++
 tb/tb_knight_scanner.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// Shared definitions for the knight scanner: display modes, sweep direction
// and the lamp one-hot decoder.
package knight_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_TRAIL  = 2'd3;

    localparam int unsigned MAX_N = 64;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // One lamp lit at pos; positions outside the n-lamp bank decode to dark.
    function automatic logic [MAX_N-1:0] onehot(input logic [5:0] pos, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (32'(pos) < n) begin
            v = MAX_N'(1) << pos;
        end
        return v;
    endfunction

endpackage

// File: rtl/knight_prescaler.sv
// Step-rate prescaler: ticks once every rate+1 enabled cycles.
module knight_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] rate,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= so that lowering rate below the running count ticks immediately.
    assign tick = en && (cnt_q >= rate);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/knight_scanner.sv
// N-lamp scanner: ping-pong or rotating head with bounce/rotate/fill/trail
// display decode and step/cycle strobes.
module knight_scanner
    import knight_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic                  ck,
    input  logic                  res,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [DIV_W-1:0]      rate,
    output logic [N-1:0]          out,
    output logic [$clog2(N)-1:0]  pos,
    output logic                  step,
    output logic                  cyc
);

    localparam int unsigned PW = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] pos_q,  pos_d;
    logic [PW-1:0] prev_q, prev_d;
    dir_e          dir_q,  dir_d;
    logic [1:0]    mode_q;
    logic          step_q, step_d;
    logic          cyc_q,  cyc_d;

    logic tick_c;
    logic restart_c;
    logic adv_c;

    assign restart_c = (mode != mode_q);
    assign adv_c     = tick_c && !restart_c;

    knight_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .ck   (ck),
        .res  (res),
        .en   (en),
        .clr  (restart_c),
        .rate (rate),
        .tick (tick_c)
    );

    // Head sequencer; a mode change restarts the pattern and beats any tick.
    always_comb begin
        pos_d  = pos_q;
        prev_d = prev_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        cyc_d  = 1'b0;
        if (restart_c) begin
            pos_d  = '0;
            prev_d = '0;
            dir_d  = DIR_UP;
        end else if (adv_c) begin
            prev_d = pos_q;
            step_d = 1'b1;
            if (mode_q == MODE_ROTATE) begin
                dir_d = DIR_UP;
                pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
            end else if (dir_q == DIR_UP) begin
                if (pos_q < LAST) begin
                    pos_d = pos_q + PW'(1);
                end else begin
                    dir_d = DIR_DOWN;
                    pos_d = LAST - PW'(1);
                end
            end else begin
                if (pos_q != '0) begin
                    pos_d = pos_q - PW'(1);
                end else begin
                    dir_d = DIR_UP;
                    pos_d = PW'(1);
                end
            end
            cyc_d = (pos_d == '0);
        end
    end

    always_ff @(posedge ck) begin
        if (!res) begin
            pos_q  <= '0;
            prev_q <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_BOUNCE;
            step_q <= 1'b0;
            cyc_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            prev_q <= prev_d;
            dir_q  <= dir_d;
            mode_q <= mode;
            step_q <= step_d;
            cyc_q  <= cyc_d;
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        out = '0;
        case (mode_q)
            MODE_FILL: begin
                for (int i = 0; i < int'(N); i++) begin
                    out[i] = (PW'(i) <= pos_q);
                end
            end
            MODE_TRAIL: out = N'(onehot(6'(pos_q), N) | onehot(6'(prev_q), N));
            default:    out = N'(onehot(6'(pos_q), N));
        endcase
    end

    assign pos  = pos_q;
    assign step = step_q;
    assign cyc  = cyc_q;

endmodule

// File: tb/tb_knight_scanner.sv
// Bench for knight_scanner: three lamp counts (8, 2, 13) run in lockstep
// against a pattern-index reference model.
module tb_knight_scanner;

    logic        ck;
    logic        res;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] rate;

    logic [7:0]  out8;  logic [2:0] pos8;  logic step8;  logic cyc8;
    logic [1:0]  out2;  logic [0:0] pos2;  logic step2;  logic cyc2;
    logic [12:0] out13; logic [3:0] pos13; logic step13; logic cyc13;

    knight_scanner #(.N(8),  .DIV_W(16)) u_n8  (.ck(ck), .res(res), .en(en), .mode(mode), .rate(rate),
                                                .out(out8),  .pos(pos8),  .step(step8),  .cyc(cyc8));
    knight_scanner #(.N(2),  .DIV_W(16)) u_n2  (.ck(ck), .res(res), .en(en), .mode(mode), .rate(rate),
                                                .out(out2),  .pos(pos2),  .step(step2),  .cyc(cyc2));
    knight_scanner #(.N(13), .DIV_W(16)) u_n13 (.ck(ck), .res(res), .en(en), .mode(mode), .rate(rate),
                                                .out(out13), .pos(pos13), .step(step13), .cyc(cyc13));

    logic [63:0] dout  [3];
    logic [7:0]  dpos  [3];
    logic        dstep [3];
    logic        dcyc  [3];

    assign dout[0] = 64'(out8);  assign dpos[0] = 8'(pos8);  assign dstep[0] = step8;  assign dcyc[0] = cyc8;
    assign dout[1] = 64'(out2);  assign dpos[1] = 8'(pos2);  assign dstep[1] = step2;  assign dcyc[1] = cyc2;
    assign dout[2] = 64'(out13); assign dpos[2] = 8'(pos13); assign dstep[2] = step13; assign dcyc[2] = cyc13;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pattern index k within the period, plus previous head.
    int m_cnt;
    int m_mode;
    int m_k    [3];
    int m_prev [3];
    bit m_step;
    bit m_cyc  [3];

    function automatic int nv(int j);
        case (j)
            0:       return 8;
            1:       return 2;
            default: return 13;
        endcase
    endfunction

    function automatic int mper(int n, int md);
        return (md == 1) ? n : 2 * n - 2;
    endfunction

    function automatic int mpos(int n, int md, int kk);
        if (md == 1) return kk % n;
        return (kk < n) ? kk : 2 * n - 2 - kk;
    endfunction

    function automatic logic [63:0] mout(int n, int md, int p, int pv);
        case (md)
            2:       return (64'd1 << (p + 1)) - 64'd1;
            3:       return (64'd1 << p) | (64'd1 << pv);
            default: return 64'd1 << p;
        endcase
    endfunction

    function automatic logic [73:0] exp_vec(int j);
        int p;
        p = mpos(nv(j), m_mode, m_k[j]);
        return {mout(nv(j), m_mode, p, m_prev[j]), 8'(p), m_step, m_cyc[j]};
    endfunction

    function automatic logic [73:0] act_vec(int j);
        return {dout[j], dpos[j], dstep[j], dcyc[j]};
    endfunction

    task automatic model_update();
        bit tick;
        if (!res) begin
            m_cnt = 0; m_mode = 0; m_step = 0;
            for (int j = 0; j < 3; j++) begin m_k[j] = 0; m_prev[j] = 0; m_cyc[j] = 0; end
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_cnt = 0; m_step = 0;
            for (int j = 0; j < 3; j++) begin m_k[j] = 0; m_prev[j] = 0; m_cyc[j] = 0; end
        end else begin
            tick = en && (m_cnt >= int'(rate));
            m_step = tick;
            if (tick) m_cnt = 0;
            else if (en) m_cnt = m_cnt + 1;
            for (int j = 0; j < 3; j++) begin
                m_cyc[j] = 0;
                if (tick) begin
                    m_prev[j] = mpos(nv(j), m_mode, m_k[j]);
                    m_k[j]    = (m_k[j] + 1) % mper(nv(j), m_mode);
                    m_cyc[j]  = (mpos(nv(j), m_mode, m_k[j]) == 0);
                end
            end
        end
    endtask

    task automatic clk_cycle();
        model_update();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b0; en = 1'b1; mode = 2'd0; rate = 16'd0;
        clk_cycle();
        clk_cycle();
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (dout[j] !== 64'd1 || dpos[j] !== 8'd0 || dstep[j] !== 1'b0 || dcyc[j] !== 1'b0) begin
                n_err++;
                $display("FAIL reset[N=%0d]: out=%h pos=%0d step=%b cyc=%b, required out=1 pos=0 step=0 cyc=0",
                         nv(j), dout[j], dpos[j], dstep[j], dcyc[j]);
            end
        end
    endtask

    task automatic test_bounce();
        int last;
        last = 0;
        res = 1'b1; en = 1'b1; mode = 2'd0; rate = 16'd0;
        for (int c = 1; c <= 42; c++) begin
            clk_cycle();
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (act_vec(j) !== exp_vec(j)) begin
                    n_err++;
                    $display("FAIL bounce[N=%0d] c%0d: got %h, expected %h", nv(j), c, act_vec(j), exp_vec(j));
                end
            end
            n_cmp++;
            if (dstep[0] !== 1'b1) begin
                n_err++;
                $display("FAIL bounce_step c%0d: step=%b, required 1", c, dstep[0]);
            end
            if (dcyc[0] === 1'b1) begin
                n_cmp++;
                if (c - last != 14) begin
                    n_err++;
                    $display("FAIL bounce_cyc_period: interval %0d, required 14", c - last);
                end
                last = c;
            end
        end
    endtask

    task automatic test_rate_enable();
        int steps;
        logic [63:0] o_hold;
        logic [7:0]  p_hold;
        bit found;
        steps = 0;
        rate = 16'd2;
        for (int c = 0; c < 30; c++) begin
            clk_cycle();
            if (dstep[0] === 1'b1) steps++;
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (act_vec(j) !== exp_vec(j)) begin
                    n_err++;
                    $display("FAIL rate[N=%0d] c%0d: got %h, expected %h", nv(j), c, act_vec(j), exp_vec(j));
                end
            end
        end
        n_cmp++;
        if (steps != 10) begin
            n_err++;
            $display("FAIL rate_step_count: %0d steps in 30 cycles, required 10", steps);
        end
        clk_cycle();
        o_hold = dout[0]; p_hold = dpos[0];
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clk_cycle();
            n_cmp++;
            if (dout[0] !== o_hold || dpos[0] !== p_hold || dstep[0] !== 1'b0 || dcyc[0] !== 1'b0) begin
                n_err++;
                $display("FAIL freeze c%0d: out=%h pos=%0d step=%b, required out=%h pos=%0d step=0",
                         c, dout[0], dpos[0], dstep[0], o_hold, p_hold);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            clk_cycle();
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (act_vec(j) !== exp_vec(j)) begin
                    n_err++;
                    $display("FAIL resume[N=%0d] c%0d: got %h, expected %h", nv(j), c, act_vec(j), exp_vec(j));
                end
            end
        end
        rate = 16'd9;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            clk_cycle();
            n_cmp++;
            if (act_vec(0) !== exp_vec(0)) begin
                n_err++;
                $display("FAIL rate9 c%0d: got %h, expected %h", c, act_vec(0), exp_vec(0));
            end
            if (m_cnt == 5) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL rate_lower_setup: count never reached 5, required within 30 cycles");
        end
        rate = 16'd1;
        clk_cycle();
        n_cmp++;
        if (dstep[0] !== 1'b1 || act_vec(0) !== exp_vec(0)) begin
            n_err++;
            $display("FAIL rate_lower_tick: step=%b state=%h, required step=1 state=%h", dstep[0], act_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_rotate();
        int last;
        logic [7:0] prev_pos;
        mode = 2'd1; rate = 16'd0;
        clk_cycle();
        n_cmp++;
        if (dout[0] !== 64'd1 || dpos[0] !== 8'd0 || dstep[0] !== 1'b0 || dcyc[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rotate_restart: out=%h pos=%0d step=%b cyc=%b, required 1/0/0/0", dout[0], dpos[0], dstep[0], dcyc[0]);
        end
        last = 0;
        prev_pos = dpos[0];
        for (int c = 1; c <= 24; c++) begin
            clk_cycle();
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (act_vec(j) !== exp_vec(j)) begin
                    n_err++;
                    $display("FAIL rotate[N=%0d] c%0d: got %h, expected %h", nv(j), c, act_vec(j), exp_vec(j));
                end
            end
            if (dcyc[0] === 1'b1) begin
                n_cmp++;
                if (c - last != 8 || prev_pos !== 8'd7 || dpos[0] !== 8'd0) begin
                    n_err++;
                    $display("FAIL rotate_wrap: interval %0d from pos %0d to %0d, required 8 from 7 to 0", c - last, prev_pos, dpos[0]);
                end
                last = c;
            end
            prev_pos = dpos[0];
        end
    endtask

    task automatic test_fill_trail();
        logic [7:0] tf [14];
        logic [7:0] tt [14];
        tf = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
        tt = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
        for (int m = 2; m <= 3; m++) begin
            mode = 2'(m); rate = 16'd0;
            clk_cycle();
            n_cmp++;
            if (out8 !== 8'h01) begin
                n_err++;
                $display("FAIL mode%0d_restart: out=%h, required 01", m, out8);
            end
            for (int c = 0; c < 14; c++) begin
                clk_cycle();
                n_cmp++;
                if (out8 !== ((m == 2) ? tf[c] : tt[c])) begin
                    n_err++;
                    $display("FAIL mode%0d_seq step%0d: out=%h, required %h", m, c, out8, (m == 2) ? tf[c] : tt[c]);
                end
                for (int j = 1; j < 3; j++) begin
                    n_cmp++;
                    if (act_vec(j) !== exp_vec(j)) begin
                        n_err++;
                        $display("FAIL mode%0d[N=%0d] c%0d: got %h, expected %h", m, nv(j), c, act_vec(j), exp_vec(j));
                    end
                end
            end
        end
    endtask

    task automatic test_mode_change();
        bit found;
        mode = 2'd0; rate = 16'd3;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            clk_cycle();
            n_cmp++;
            if (act_vec(0) !== exp_vec(0)) begin
                n_err++;
                $display("FAIL mode_change_run c%0d: got %h, expected %h", c, act_vec(0), exp_vec(0));
            end
            if (mpos(8, 0, m_k[0]) == 5 && m_cnt >= 3) found = 1;
        end
        n_cmp++;
        if (!found || dpos[0] !== 8'd5) begin
            n_err++;
            $display("FAIL mode_change_setup: pos=%0d, required pos 5 with tick due", dpos[0]);
        end
        mode = 2'd2;
        clk_cycle();
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (dout[j] !== 64'd1 || dpos[j] !== 8'd0 || dstep[j] !== 1'b0 || dcyc[j] !== 1'b0) begin
                n_err++;
                $display("FAIL mode_change_restart[N=%0d]: out=%h pos=%0d step=%b cyc=%b, required 1/0/0/0",
                         nv(j), dout[j], dpos[j], dstep[j], dcyc[j]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit found;
        int ncyc [3];
        mode = 2'd0; rate = 16'd0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            clk_cycle();
            if (m_k[0] == 10) found = 1;
        end
        n_cmp++;
        if (!found || dpos[0] !== 8'd4) begin
            n_err++;
            $display("FAIL reset_mid_setup: pos=%0d, required 4 on the down sweep", dpos[0]);
        end
        res = 1'b0;
        clk_cycle();
        res = 1'b1;
        for (int j = 0; j < 3; j++) begin
            ncyc[j] = 0;
            n_cmp++;
            if (dout[j] !== 64'd1 || dpos[j] !== 8'd0 || dstep[j] !== 1'b0 || dcyc[j] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid[N=%0d]: out=%h pos=%0d step=%b cyc=%b, required 1/0/0/0",
                         nv(j), dout[j], dpos[j], dstep[j], dcyc[j]);
            end
        end
        for (int c = 0; c < 48; c++) begin
            clk_cycle();
            for (int j = 0; j < 3; j++) begin
                if (dcyc[j] === 1'b1) ncyc[j]++;
                n_cmp++;
                if (act_vec(j) !== exp_vec(j)) begin
                    n_err++;
                    $display("FAIL reset_mid_run[N=%0d] c%0d: got %h, expected %h", nv(j), c, act_vec(j), exp_vec(j));
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (ncyc[j] != 48 / (2 * nv(j) - 2)) begin
                n_err++;
                $display("FAIL period[N=%0d]: %0d cyc pulses in 48 steps, required %0d", nv(j), ncyc[j], 48 / (2 * nv(j) - 2));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            res  = ($urandom_range(0, 99) != 0);
            en   = ($urandom_range(0, 9) != 0);
            rate = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            clk_cycle();
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (act_vec(j) !== exp_vec(j)) begin
                    n_err++;
                    $display("FAIL random[N=%0d] c%0d: got %h, expected %h", nv(j), c, act_vec(j), exp_vec(j));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_rate_enable();
        test_rotate();
        test_fill_trail();
        test_mode_change();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
